// File: rtl/line_engine_if.sv
// Command/pixel bus between the user-interface logic (master) and the line engine (slave).
// The pixel side (x, y, colour, plot) feeds the VGA frame-buffer adapter.
interface line_engine_if #(
    parameter int unsigned X_WIDTH      = 9,
    parameter int unsigned Y_WIDTH      = 8,
    parameter int unsigned COLOUR_WIDTH = 3
);
    logic                    go;
    logic                    mode;
    logic [X_WIDTH-1:0]      new_x;
    logic [Y_WIDTH-1:0]      new_y;
    logic [COLOUR_WIDTH-1:0] new_colour;
    logic                    ready;
    logic [X_WIDTH-1:0]      x;
    logic [Y_WIDTH-1:0]      y;
    logic [COLOUR_WIDTH-1:0] colour;
    logic                    plot;
    logic                    done;

    modport master (
        output go, mode, new_x, new_y, new_colour,
        input  ready, x, y, colour, plot, done
    );

    modport slave (
        input  go, mode, new_x, new_y, new_colour,
        output ready, x, y, colour, plot, done
    );
endinterface

// File: rtl/line_engine.sv
// Bresenham polyline engine: draws from the held origin to each accepted endpoint at one
// pixel per clock, then makes that endpoint the new origin. Off-screen pixels are stepped but not plotted.
module line_engine #(
    parameter int unsigned X_WIDTH      = 9,
    parameter int unsigned Y_WIDTH      = 8,
    parameter int unsigned COLOUR_WIDTH = 3,
    parameter int unsigned X_MAX        = 319,
    parameter int unsigned Y_MAX        = 239
) (
    input logic          clk_i,
    input logic          rst_i,
    line_engine_if.slave bus_io
);
    localparam int unsigned W = ((X_WIDTH > Y_WIDTH) ? X_WIDTH : Y_WIDTH) + 2;
    localparam logic [X_WIDTH-1:0] XMaxW = X_WIDTH'(X_MAX);
    localparam logic [Y_WIDTH-1:0] YMaxW = Y_WIDTH'(Y_MAX);

    typedef enum logic [1:0] {StIdle, StSetup, StDraw, StDone} state_e;

    state_e                  state_q, state_d;
    logic                    go_q;
    logic                    md_q, md_d;
    logic [X_WIDTH-1:0]      x0_q, x0_d, x1_q, x1_d, cx_q, cx_d;
    logic [Y_WIDTH-1:0]      y0_q, y0_d, y1_q, y1_d, cy_q, cy_d;
    logic [COLOUR_WIDTH-1:0] col_q, col_d, pcol_q, pcol_d;
    logic                    sxn_q, sxn_d, syn_q, syn_d;
    logic signed [W-1:0]     dx_q, dx_d, dy_q, dy_d, err_q, err_d;

    logic                    go_rise;
    logic [X_WIDTH-1:0]      x_diff;
    logic [Y_WIDTH-1:0]      y_diff;
    logic signed [W:0]       e2, dx_ext, dy_ext;

    assign go_rise = bus_io.go & ~go_q;
    assign x_diff  = (x0_q < x1_q) ? (x1_q - x0_q) : (x0_q - x1_q);
    assign y_diff  = (y0_q < y1_q) ? (y1_q - y0_q) : (y0_q - y1_q);
    assign e2      = {err_q, 1'b0};
    assign dx_ext  = {dx_q[W-1], dx_q};
    assign dy_ext  = {dy_q[W-1], dy_q};

    always_comb begin
        state_d = state_q;
        md_d    = md_q;
        x0_d    = x0_q;
        y0_d    = y0_q;
        x1_d    = x1_q;
        y1_d    = y1_q;
        cx_d    = cx_q;
        cy_d    = cy_q;
        col_d   = col_q;
        pcol_d  = pcol_q;
        sxn_d   = sxn_q;
        syn_d   = syn_q;
        dx_d    = dx_q;
        dy_d    = dy_q;
        err_d   = err_q;
        unique case (state_q)
            StIdle: begin
                if (go_rise) begin
                    x1_d    = bus_io.new_x;
                    y1_d    = bus_io.new_y;
                    col_d   = bus_io.new_colour;
                    md_d    = bus_io.mode;
                    state_d = StSetup;
                end
            end
            StSetup: begin
                if (md_q) begin
                    state_d = StDone;
                end else begin
                    dx_d    = signed'(W'(x_diff));
                    dy_d    = -signed'(W'(y_diff));
                    err_d   = signed'(W'(x_diff)) - signed'(W'(y_diff));
                    sxn_d   = !(x0_q < x1_q);
                    syn_d   = !(y0_q < y1_q);
                    cx_d    = x0_q;
                    cy_d    = y0_q;
                    pcol_d  = col_q;
                    state_d = StDraw;
                end
            end
            StDraw: begin
                if (cx_q == x1_q && cy_q == y1_q) begin
                    state_d = StDone;
                end else begin
                    // Both axis decisions use the pre-step error term.
                    if (e2 >= dy_ext) begin
                        err_d = err_d + dy_q;
                        cx_d  = sxn_q ? (cx_q - 1'b1) : (cx_q + 1'b1);
                    end
                    if (e2 <= dx_ext) begin
                        err_d = err_d + dx_q;
                        cy_d  = syn_q ? (cy_q - 1'b1) : (cy_q + 1'b1);
                    end
                end
            end
            StDone: begin
                x0_d    = x1_q;
                y0_d    = y1_q;
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= StIdle;
            go_q    <= 1'b0;
            md_q    <= 1'b0;
            x0_q    <= '0;
            y0_q    <= '0;
            x1_q    <= '0;
            y1_q    <= '0;
            cx_q    <= '0;
            cy_q    <= '0;
            col_q   <= '0;
            pcol_q  <= '0;
            sxn_q   <= 1'b0;
            syn_q   <= 1'b0;
            dx_q    <= '0;
            dy_q    <= '0;
            err_q   <= '0;
        end else begin
            state_q <= state_d;
            go_q    <= bus_io.go;
            md_q    <= md_d;
            x0_q    <= x0_d;
            y0_q    <= y0_d;
            x1_q    <= x1_d;
            y1_q    <= y1_d;
            cx_q    <= cx_d;
            cy_q    <= cy_d;
            col_q   <= col_d;
            pcol_q  <= pcol_d;
            sxn_q   <= sxn_d;
            syn_q   <= syn_d;
            dx_q    <= dx_d;
            dy_q    <= dy_d;
            err_q   <= err_d;
        end
    end

    // Status outputs decode the state register so a reset drops them without a clock.
    assign bus_io.ready  = (state_q == StIdle);
    assign bus_io.done   = (state_q == StDone);
    assign bus_io.plot   = (state_q == StDraw) && (cx_q <= XMaxW) && (cy_q <= YMaxW);
    assign bus_io.x      = cx_q;
    assign bus_io.y      = cy_q;
    assign bus_io.colour = pcol_q;
endmodule

// File: tb/tb_line_engine.sv
// Directed bench for line_engine: polylines, a single point, clipping, dropped go edges
// and a reset that aborts a line in progress.
module tb_line_engine;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;
    int   px[$];
    int   py[$];
    int   done_at;
    int   bad_col;

    always #5 clk = ~clk;

    line_engine_if #(.X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(3)) bus ();

    line_engine #(
        .X_WIDTH(9), .Y_WIDTH(8), .COLOUR_WIDTH(3), .X_MAX(319), .Y_MAX(239)
    ) dut (
        .clk_i (clk),
        .rst_i (rst),
        .bus_io(bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $display("FAIL %s: observed %0d expected %0d", tag, obs, exp);
        end
    endtask

    // Issue one command; record plotted pixels and the cycle (relative to edge E) of done.
    task automatic run_cmd(input bit md, input int nx, input int ny, input int col,
                           input int toggle_at, input bit hold);
        px.delete();
        py.delete();
        done_at    = -1;
        bad_col    = 0;
        bus.mode       = md;
        bus.new_x      = 9'(nx);
        bus.new_y      = 8'(ny);
        bus.new_colour = 3'(col);
        bus.go         = 1'b1;
        tick();
        chk("ready_after_accept", bus.ready, 1'b0);
        if (!hold) bus.go = 1'b0;
        for (int c = 1; c <= 400 && done_at < 0; c++) begin
            if (bus.plot === 1'b1) begin
                px.push_back(int'(bus.x));
                py.push_back(int'(bus.y));
                if (bus.colour !== 3'(col)) bad_col++;
            end
            if (bus.done === 1'b1) done_at = c;
            if (toggle_at != 0 && c == toggle_at) bus.go = 1'b1;
            if (toggle_at != 0 && c == toggle_at + 1) bus.go = 1'b0;
            if (done_at < 0) tick();
        end
        tick();
        chk("ready_after_done", bus.ready, 1'b1);
        chk("done_single_pulse", bus.done, 1'b0);
        chk("colour_during_plot", bad_col, 0);
    endtask

    initial begin
        int ey[11];
        ey = '{0, 1, 1, 2, 2, 3, 3, 4, 4, 5, 5};
        bus.go = 1'b0;
        bus.mode = 1'b0;
        bus.new_x = '0;
        bus.new_y = '0;
        bus.new_colour = '0;
        tick();
        tick();
        chk("rst_ready", bus.ready, 1'b1);
        chk("rst_plot", bus.plot, 1'b0);
        chk("rst_done", bus.done, 1'b0);
        chk("rst_x", bus.x, 0);
        chk("rst_y", bus.y, 0);
        chk("rst_colour", bus.colour, 0);
        @(negedge clk);
        rst = 1'b0;
        tick();

        // (0,0) -> (10,5)
        run_cmd(1'b0, 10, 5, 5, 0, 1'b0);
        chk("diag_done_at", done_at, 13);
        chk("diag_npix", px.size(), 11);
        for (int i = 0; i < px.size() && i < 11; i++) begin
            chk($sformatf("diag_x%0d", i), px[i], i);
            chk($sformatf("diag_y%0d", i), py[i], ey[i]);
        end
        tick();

        // (10,5) -> (10,0)
        run_cmd(1'b0, 10, 0, 2, 0, 1'b0);
        chk("vert_done_at", done_at, 8);
        chk("vert_npix", px.size(), 6);
        for (int i = 0; i < px.size(); i++) begin
            chk($sformatf("vert_x%0d", i), px[i], 10);
            chk($sformatf("vert_y%0d", i), py[i], 5 - i);
        end
        tick();

        // Single point at the current origin
        run_cmd(1'b0, 10, 0, 7, 0, 1'b0);
        chk("point_done_at", done_at, 3);
        chk("point_npix", px.size(), 1);
        for (int i = 0; i < px.size(); i++) begin
            chk("point_x", px[i], 10);
            chk("point_y", py[i], 0);
        end
        tick();

        // Move only, then a line crossing the right edge; a go pulse mid-line must be dropped
        run_cmd(1'b1, 300, 200, 1, 0, 1'b0);
        chk("move_done_at", done_at, 2);
        chk("move_npix", px.size(), 0);
        tick();
        run_cmd(1'b0, 330, 200, 4, 10, 1'b0);
        chk("clip_done_at", done_at, 33);
        chk("clip_npix", px.size(), 20);
        for (int i = 0; i < px.size(); i++) begin
            chk($sformatf("clip_x%0d", i), px[i], 300 + i);
            chk($sformatf("clip_y%0d", i), py[i], 200);
        end
        tick();
        chk("drop_idle_ready", bus.ready, 1'b1);

        // go held high across done must not start another command
        run_cmd(1'b1, 0, 0, 0, 0, 1'b1);
        chk("hold_done_at", done_at, 2);
        for (int i = 0; i < 3; i++) begin
            tick();
            chk($sformatf("hold_ready%0d", i), bus.ready, 1'b1);
            chk($sformatf("hold_plot%0d", i), bus.plot, 1'b0);
        end
        bus.go = 1'b0;
        tick();

        // Reset during the 4th DRAW cycle of (0,0) -> (50,50)
        bus.mode = 1'b0;
        bus.new_x = 9'd50;
        bus.new_y = 8'd50;
        bus.new_colour = 3'd6;
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
        for (int i = 0; i < 4; i++) tick();
        chk("abort_plot_before", bus.plot, 1'b1);
        chk("abort_x_before", bus.x, 3);
        #2;
        rst = 1'b1;
        #1;
        chk("abort_plot", bus.plot, 1'b0);
        chk("abort_done", bus.done, 1'b0);
        chk("abort_ready", bus.ready, 1'b1);
        @(negedge clk);
        rst = 1'b0;
        tick();
        run_cmd(1'b0, 2, 1, 3, 0, 1'b0);
        chk("post_rst_done_at", done_at, 5);
        chk("post_rst_npix", px.size(), 3);
        if (px.size() == 3) begin
            chk("post_rst_x0", px[0], 0);
            chk("post_rst_y0", py[0], 0);
            chk("post_rst_x1", px[1], 1);
            chk("post_rst_y1", py[1], 1);
            chk("post_rst_x2", px[2], 2);
            chk("post_rst_y2", py[2], 1);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
